matrix_key_scan: RTL and testbench
==================================

// Module: matrix_key_scan
// PURPOSE
//   Scans the 4x4 matrix keypad, debounces press and release, and emits one key event per press.
//   Each event is a one-cycle key_value strobe plus row_col = {row[3:0], col[3:0]}, both
//   active-low one-hot (e.g. 8'h77, 8'h7b, 8'hbe).
//   Sits between the keypad pins and key_control, which consumes row_col/key_value.
// PARAMETERS
//   DEBOUNCE_CYC  1_000_000  stable cycles for press/release qualification (20 ms @ 50 MHz)
//   SETTLE_CYC    16         cycles after a column change before rows are sampled (>= 3)
// PORTS
//   clk        in   1  system clock, single clock domain
//   rst_n      in   1  asynchronous reset, ACTIVE-HIGH (1 = reset), port name kept as rst_n
//   key_row    in   4  keypad row inputs, pulled up, low = pressed path; asynchronous
//   key_col    out  4  keypad column drives, active-low
//   row_col    out  8  {row_sync, key_col} of the last accepted key; held until next event
//   key_value  out  1  one-cycle strobe, row_col valid in the same cycle
//   key_down   out  1  high from the strobe cycle until release is qualified
// BEHAVIOUR
//   Reset values: key_col=4'h0, row_col=8'hff, key_value=0, key_down=0, state=IDLE, counters=0.
//   Synchronization: key_row passes through a 2-flop synchronizer (row_sync). All decisions use row_sync.
//   FSM states: IDLE, DEBOUNCE, SCAN, REPORT, RELEASE.
//   IDLE:
//     - key_col=4'h0.
//     - If row_sync!=4'hf, go to DEBOUNCE with cnt=0.
//   DEBOUNCE:
//     - key_col=4'h0.
//     - If row_sync==4'hf at any cycle, go to IDLE (glitch rejected, no strobe).
//     - Otherwise cnt+1. When cnt==DEBOUNCE_CYC-1, go to SCAN with idx=0 and cnt=0.
//   SCAN:
//     - key_col=~(4'b1<<idx). Columns are scanned bit0 first.
//     - Wait SETTLE_CYC cycles, then sample row_sync once.
//     - Exactly one zero bit: latch row_col={row_sync,key_col}, go to REPORT.
//     - More than one zero bit (ghost/multi-row): go to RELEASE with no strobe.
//     - 4'hf: idx+1 and settle again.
//     - idx==3 with nothing found: go to IDLE (no strobe).
//   REPORT (one cycle):
//     - key_value=1, key_down<=1, key_col=4'h0.
//     - Next state is RELEASE with cnt=0.
//   RELEASE:
//     - key_col=4'h0.
//     - Any row_sync!=4'hf resets cnt to 0.
//     - When row_sync==4'hf holds for DEBOUNCE_CYC consecutive cycles, key_down<=0 and go to IDLE.
//   Rules:
//     - At most one strobe per physical press. Held keys never repeat.
//     - A second key pressed while the first is held is ignored.
//     - Counters are sized $clog2(max(DEBOUNCE_CYC,SETTLE_CYC)+1) bits and never wrap,
//       because each is cleared on its state exit.
//     - Reset asserted mid-scan or mid-strobe returns all outputs to their reset values in the
//       same cycle, and no strobe is produced after deassert until a fresh debounce completes.
//   Latency (press to key_value):
//     2 (sync) + DEBOUNCE_CYC + (idx+1)*SETTLE_CYC + 1 cycles, +/-1 cycle.
// STRUCTURE
//   Package key_scan_pkg:
//     - state encodings (localparam, 3-bit)
//     - ROW_IDLE = 4'hf
//     - COL_ALL = 4'h0
//     - function onehot0_n(row) -> exactly-one-zero test
//   Sub-module key_sync: 2-flop synchronizer, parameterized width, async active-high reset to all 1s.
//   FSM, counters and output registers stay in matrix_key_scan. All outputs are registered.
// TESTING (bench uses DEBOUNCE_CYC=8, SETTLE_CYC=4; keypad model shorts row r to col c)
//   1. Press key at row bit3/col bit3, hold 100 cycles.
//      -> exactly one key_value pulse with row_col=8'h77, key_down=1 until release plus 8 cycles.
//   2. Press row bit2/col bit1 (8'hbd), with 5-cycle bounce pulses before a stable hold.
//      -> no strobe during bounce, then one strobe with row_col=8'hbd.
//   3. 3-cycle glitch on key_row[0] while idle.
//      -> FSM returns to IDLE, key_value never asserted, row_col stays 8'hff.
//   4. Hold 8'h7b, then also press 8'h7d, then release both.
//      -> single strobe 8'h7b only, and key_down drops only after both keys are released.
//   5. Press two keys in the same column at rows bit3 and bit2.
//      -> no strobe, key_down=0, FSM waits in RELEASE until all released.
//   6. Assert rst_n (=1) during SCAN.
//      -> key_col=0, row_col=8'hff, key_value=0 immediately.
//      After deassert with the key still held: one strobe follows after a full debounce.

Source files
------------

// File: rtl/matrix_key_scan_pkg.sv
// Shared constants and helpers for the 4x4 keypad scanner.
//   - FSM state encodings (3-bit, plain localparams so older tools can read them)
//   - ROW_IDLE / COL_ALL pin levels
//   - onehot0_n(): true when exactly one bit of an active-low vector is low
//   - col_drive(): active-low column drive for a column index
package key_scan_pkg;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_DEBOUNCE = 3'd1;
  localparam logic [2:0] ST_SCAN     = 3'd2;
  localparam logic [2:0] ST_REPORT   = 3'd3;
  localparam logic [2:0] ST_RELEASE  = 3'd4;

  // Rows are pulled up: all ones means no key is closing any row.
  localparam logic [3:0] ROW_IDLE = 4'hf;
  // All columns driven low so any pressed key pulls its row down.
  localparam logic [3:0] COL_ALL  = 4'h0;

  function automatic logic onehot0_n(input logic [3:0] row);
    logic [3:0] z;
    z = ~row;
    return (z != 4'h0) && ((z & (z - 4'h1)) == 4'h0);
  endfunction

  function automatic logic [3:0] col_drive(input logic [1:0] idx);
    return ~(4'b0001 << idx);
  endfunction

endpackage

// File: rtl/matrix_key_scan_if.sv
// Keypad pin and key-event bundle.
//   key_row   : keypad rows (pulled up, asynchronous), into the scanner
//   key_col   : active-low column drives, out of the scanner
//   row_col   : {rows, cols} of the last accepted key, held until the next event
//   key_value : one-cycle event strobe; row_col is valid in the same cycle
//   key_down  : high from the strobe until the release is debounced
//   state     : scanner FSM state, for observation only
// Handshake: key_value is a plain strobe without back-pressure. The consumer
// must take row_col in the strobe cycle; no ready signal exists and none is
// waited for.
interface matrix_key_scan_if;
  logic [3:0] key_row;
  logic [3:0] key_col;
  logic [7:0] row_col;
  logic       key_value;
  logic       key_down;
  logic [2:0] state;

  // Scanner side.
  modport master (
    input  key_row,
    output key_col, row_col, key_value, key_down, state
  );

  // Keypad / consumer side.
  modport slave (
    output key_row,
    input  key_col, row_col, key_value, key_down, state
  );
endinterface

// File: rtl/matrix_key_scan_sync.sv
// key_sync: two-flop synchronizer for asynchronous level inputs.
//   clk  : destination clock
//   rst  : asynchronous active-high reset; flops reset to all ones (idle rows)
//   i_d  : asynchronous input
//   o_q  : synchronized output, two cycles behind i_d
module key_sync #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meta <= '1;
      r_sync <= '1;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/matrix_key_scan.sv
// matrix_key_scan: scans a 4x4 keypad, debounces press and release, and emits
// one key event per physical press.
//   clk    : system clock
//   rst_n  : asynchronous reset, ACTIVE-HIGH despite the name
//   bus    : matrix_key_scan_if.master (keypad pins, key event, state)
// All outputs are registered. While idle, debouncing and releasing, every
// column is driven low so any key is seen; only SCAN walks the columns.
module matrix_key_scan
  import key_scan_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 1_000_000,
  parameter int SETTLE_CYC   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  matrix_key_scan_if.master  bus
);

  localparam int MAX_CYC = (DEBOUNCE_CYC > SETTLE_CYC) ? DEBOUNCE_CYC : SETTLE_CYC;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  logic [3:0]       w_row_sync;
  logic             w_deb_done;
  logic             w_settled;

  logic [2:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_idx;
  logic [3:0]       r_key_col;
  logic [7:0]       r_row_col;
  logic             r_key_value;
  logic             r_key_down;

  key_sync #(.WIDTH(4)) u_sync (
    .clk (clk),
    .rst (rst_n),
    .i_d (bus.key_row),
    .o_q (w_row_sync)
  );

  assign w_deb_done = (r_cnt == CNT_W'(DEBOUNCE_CYC - 1));
  assign w_settled  = (r_cnt == CNT_W'(SETTLE_CYC - 1));

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_idx       <= 2'd0;
      r_key_col   <= COL_ALL;
      r_row_col   <= 8'hff;
      r_key_value <= 1'b0;
      r_key_down  <= 1'b0;
    end else begin
      r_key_value <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_key_col <= COL_ALL;
          r_cnt     <= '0;
          if (w_row_sync != ROW_IDLE) begin
            r_state <= ST_DEBOUNCE;
          end
        end

        ST_DEBOUNCE: begin
          r_key_col <= COL_ALL;
          if (w_row_sync == ROW_IDLE) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
          end else if (w_deb_done) begin
            r_state   <= ST_SCAN;
            r_cnt     <= '0;
            r_idx     <= 2'd0;
            r_key_col <= col_drive(2'd0);
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end

        ST_SCAN: begin
          // row_sync lags the pins by two cycles, so the settle window must
          // cover both the column change and the synchronizer.
          if (!w_settled) begin
            r_cnt <= r_cnt + CNT_W'(1);
          end else begin
            r_cnt <= '0;
            if (onehot0_n(w_row_sync)) begin
              // Strobe is registered: it is high for the whole REPORT cycle.
              r_row_col   <= {w_row_sync, r_key_col};
              r_key_value <= 1'b1;
              r_key_down  <= 1'b1;
              r_key_col   <= COL_ALL;
              r_state     <= ST_REPORT;
            end else if (w_row_sync != ROW_IDLE) begin
              // Several rows low in one column: ambiguous, wait it out.
              r_key_col <= COL_ALL;
              r_state   <= ST_RELEASE;
            end else if (r_idx == 2'd3) begin
              // Key vanished before it was located.
              r_key_col <= COL_ALL;
              r_state   <= ST_IDLE;
            end else begin
              r_idx     <= r_idx + 2'd1;
              r_key_col <= col_drive(r_idx + 2'd1);
            end
          end
        end

        ST_REPORT: begin
          r_key_col <= COL_ALL;
          r_cnt     <= '0;
          r_state   <= ST_RELEASE;
        end

        ST_RELEASE: begin
          r_key_col <= COL_ALL;
          if (w_row_sync != ROW_IDLE) begin
            r_cnt <= '0;
          end else if (w_deb_done) begin
            r_cnt      <= '0;
            r_key_down <= 1'b0;
            r_state    <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end

        default: begin
          r_state   <= ST_IDLE;
          r_cnt     <= '0;
          r_key_col <= COL_ALL;
        end
      endcase
    end
  end

  assign bus.key_col   = r_key_col;
  assign bus.row_col   = r_row_col;
  assign bus.key_value = r_key_value;
  assign bus.key_down  = r_key_down;
  assign bus.state     = r_state;

endmodule

// File: tb/tb_matrix_key_scan.sv
// Bench for matrix_key_scan with DEBOUNCE_CYC=8, SETTLE_CYC=4. A keypad model
// shorts row r to column c for every pressed key; an extra mask can pull rows
// low directly to model glitches.
module tb_matrix_key_scan;
  import key_scan_pkg::*;

  localparam int DEB = 8;
  localparam int SET = 4;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  matrix_key_scan_if bus ();

  matrix_key_scan #(.DEBOUNCE_CYC(DEB), .SETTLE_CYC(SET)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ---------------- keypad model ----------------
  logic [3:0] keys [4];   // keys[row][col] = pressed
  logic [3:0] glitch;     // forces a row low regardless of columns
  logic [3:0] w_row;

  always_comb begin
    w_row = 4'hf;
    for (int r = 0; r < 4; r++) begin
      w_row[r] = ~(|(keys[r] & ~bus.key_col)) & ~glitch[r];
    end
  end
  assign bus.key_row = w_row;

  // ---------------- scoreboard ----------------
  int n_checks;
  int n_fail;
  int strobe_cnt;
  logic [7:0] exp_q [$];

  always @(negedge clk) begin
    if (bus.key_value) strobe_cnt++;
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    n_checks++;
    if (act < lo || act > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_key(input int r, input int c, input logic v);
    keys[r][c] = v;
  endtask

  task automatic wait_strobe(output int lat);
    lat = 0;
    while (lat < 300) begin
      @(negedge clk);
      lat++;
      if (bus.key_value) break;
    end
    if (!bus.key_value) begin
      n_checks++;
      n_fail++;
      $display("FAIL strobe_timeout: got no strobe in %0d cycles", lat);
    end
  endtask

  task automatic wait_release(output int lat);
    lat = 0;
    while (lat < 300) begin
      @(negedge clk);
      lat++;
      if (!bus.key_down) break;
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int         row;
    int         col;
    int         bounces;
    int         hold;
    logic [7:0] exp_rc;
  } vec_t;

  vec_t vecs [5];

  initial begin
    int lat;
    int nom;
    logic [7:0] exp_rc;

    n_checks   = 0;
    n_fail     = 0;
    strobe_cnt = 0;
    glitch     = 4'h0;
    for (int r = 0; r < 4; r++) keys[r] = 4'h0;

    vecs[0] = '{row: 3, col: 3, bounces: 0, hold: 100, exp_rc: 8'h77};
    vecs[1] = '{row: 2, col: 1, bounces: 3, hold: 40,  exp_rc: 8'hbd};
    vecs[2] = '{row: 0, col: 0, bounces: 0, hold: 30,  exp_rc: 8'hee};
    vecs[3] = '{row: 1, col: 2, bounces: 0, hold: 30,  exp_rc: 8'hdb};
    vecs[4] = '{row: 0, col: 3, bounces: 1, hold: 30,  exp_rc: 8'he7};

    // reset values
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_key_col",   bus.key_col,   4'h0);
    check("rst_row_col",   bus.row_col,   8'hff);
    check("rst_key_value", bus.key_value, 0);
    check("rst_key_down",  bus.key_down,  0);
    check("rst_state",     bus.state,     ST_IDLE);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);

    // 3-cycle glitch on row 0 while idle
    strobe_cnt = 0;
    glitch[0] = 1'b1;
    repeat (3) @(negedge clk);
    check("glitch_enters_debounce", bus.state, ST_DEBOUNCE);
    glitch[0] = 1'b0;
    repeat (20) @(negedge clk);
    check("glitch_state_idle", bus.state, ST_IDLE);
    check("glitch_no_strobe", strobe_cnt, 0);
    check("glitch_row_col",   bus.row_col, 8'hff);

    // table-driven single presses
    for (int v = 0; v < 5; v++) begin
      strobe_cnt = 0;
      for (int b = 0; b < vecs[v].bounces; b++) begin
        set_key(vecs[v].row, vecs[v].col, 1'b1);
        repeat (5) @(negedge clk);
        set_key(vecs[v].row, vecs[v].col, 1'b0);
        repeat (5) @(negedge clk);
      end
      if (vecs[v].bounces > 0) check("bounce_no_strobe", strobe_cnt, 0);

      exp_q.push_back(vecs[v].exp_rc);
      set_key(vecs[v].row, vecs[v].col, 1'b1);
      wait_strobe(lat);
      nom = 2 + DEB + (vecs[v].col + 1) * SET + 1;
      check_range("press_latency", lat, nom - 1, nom + 1);
      exp_rc = exp_q.pop_front();
      check("row_col", bus.row_col, exp_rc);
      check("key_down_on_strobe", bus.key_down, 1);
      repeat (vecs[v].hold) @(negedge clk);
      check("single_strobe_held", strobe_cnt, 1);
      check("key_down_held", bus.key_down, 1);
      set_key(vecs[v].row, vecs[v].col, 1'b0);
      wait_release(lat);
      check_range("release_latency", lat, DEB, DEB + 4);
      repeat (3) @(negedge clk);
      check("idle_after_release", bus.state, ST_IDLE);
      check("row_col_held", bus.row_col, exp_rc);
      check("no_repeat", strobe_cnt, 1);
    end

    // second key while first is held
    strobe_cnt = 0;
    set_key(3, 2, 1'b1);
    wait_strobe(lat);
    check("two_key_first_rc", bus.row_col, 8'h7b);
    repeat (10) @(negedge clk);
    set_key(3, 1, 1'b1);
    repeat (30) @(negedge clk);
    set_key(3, 2, 1'b0);
    repeat (20) @(negedge clk);
    check("two_key_still_down", bus.key_down, 1);
    check("two_key_state", bus.state, ST_RELEASE);
    set_key(3, 1, 1'b0);
    wait_release(lat);
    check_range("two_key_release_lat", lat, DEB, DEB + 4);
    repeat (5) @(negedge clk);
    check("two_key_one_strobe", strobe_cnt, 1);
    check("two_key_rc", bus.row_col, 8'h7b);

    // two rows in one column: ghost, no strobe
    strobe_cnt = 0;
    set_key(3, 0, 1'b1);
    set_key(2, 0, 1'b1);
    repeat (40) @(negedge clk);
    check("ghost_state_release", bus.state, ST_RELEASE);
    check("ghost_key_down", bus.key_down, 0);
    check("ghost_no_strobe", strobe_cnt, 0);
    set_key(3, 0, 1'b0);
    set_key(2, 0, 1'b0);
    repeat (20) @(negedge clk);
    check("ghost_idle", bus.state, ST_IDLE);
    check("ghost_rc_kept", bus.row_col, 8'h7b);

    // reset during SCAN, key still held afterwards
    set_key(1, 3, 1'b1);
    lat = 0;
    while (bus.state != ST_SCAN && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check("reached_scan", bus.state, ST_SCAN);
    rst_n = 1'b1;
    #1;
    check("midscan_rst_key_col",   bus.key_col,   4'h0);
    check("midscan_rst_row_col",   bus.row_col,   8'hff);
    check("midscan_rst_key_value", bus.key_value, 0);
    check("midscan_rst_state",     bus.state,     ST_IDLE);
    repeat (3) @(negedge clk);
    strobe_cnt = 0;
    rst_n = 1'b0;
    wait_strobe(lat);
    nom = 2 + DEB + 4 * SET + 1;
    check_range("post_rst_latency", lat, nom - 1, nom + 1);
    check("post_rst_rc", bus.row_col, 8'hd7);
    set_key(1, 3, 1'b0);
    wait_release(lat);
    repeat (5) @(negedge clk);
    check("post_rst_one_strobe", strobe_cnt, 1);
    check("post_rst_key_down", bus.key_down, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
